// File: rtl/seq_mult_param_if.sv
// Operand/result bundle for the shift-add sequential multiplier.
// The producer side uses master; the multiplier itself uses slave.
interface seq_mult_param_if #(
    parameter int WIDTH = 4
);
    logic                   valid;
    logic                   signed_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   ready;
    logic                   busy;
    logic [2*WIDTH-1:0]     prod;
    logic                   DONE;

    modport master (
        output valid, signed_mode, A, B,
        input  ready, busy, prod, DONE
    );

    modport slave (
        input  valid, signed_mode, A, B,
        output ready, busy, prod, DONE
    );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier with optional two's-complement mode.
// It produces one partial product per clock and holds the last result.
module seq_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_mult_param_if.slave      bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     absA;
    logic [WIDTH-1:0]     absB;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   accNext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    // -2^(W-1) negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        absA    = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        absB    = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        accNext = acc_q + (mplier_q[0] ? partial : '0);

        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d  = RUN;
                    mcand_d  = absA;
                    mplier_d = absB;
                    neg_d    = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = accNext;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    prod_d  = neg_q ? -accNext : accNext;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.busy  = (state_q != IDLE);
        bus.prod  = prod_q;
        bus.DONE  = done_q;
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=4 and WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_mult_param;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    seq_mult_param_if #(.WIDTH(4)) ifW4 ();
    seq_mult_param_if #(.WIDTH(8)) ifW8 ();

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifW4)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (ifW8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair for a single cycle; returns in the first RUN cycle.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic s);
        @(negedge clk);
        ifW4.valid       = 1'b1;
        ifW4.A           = a;
        ifW4.B           = b;
        ifW4.signed_mode = s;
        @(negedge clk);
        ifW4.valid       = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (ifW4.DONE !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int doneCount;
        int doneAt;
        int readyLow;

        rst              = 1'b0;
        ifW4.valid       = 1'b0;
        ifW4.A           = '0;
        ifW4.B           = '0;
        ifW4.signed_mode = 1'b0;
        ifW8.valid       = 1'b0;
        ifW8.A           = '0;
        ifW8.B           = '0;
        ifW8.signed_mode = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(ifW4.ready), 32'h1);
        checkOutput("rst_busy",  32'(ifW4.busy),  32'h0);
        checkOutput("rst_prod",  32'(ifW4.prod),  32'h0);
        checkOutput("rst_done",  32'(ifW4.DONE),  32'h0);
        rst = 1'b1;

        applyStimulus(4'd7, 4'd7, 1'b0);
        checkOutput("run_ready", 32'(ifW4.ready), 32'h0);
        checkOutput("run_busy",  32'(ifW4.busy),  32'h1);
        waitDone(n);
        checkOutput("u7x7_latency", 32'(n), 32'd4);
        checkOutput("u7x7_prod",    32'(ifW4.prod), 32'h31);
        checkOutput("done_ready",   32'(ifW4.ready), 32'h1);
        @(negedge clk);
        checkOutput("done_pulse",   32'(ifW4.DONE), 32'h0);
        repeat (20) @(negedge clk);
        checkOutput("u7x7_hold",    32'(ifW4.prod), 32'h31);

        applyStimulus(4'hD, 4'd5, 1'b1);
        waitDone(n);
        checkOutput("s_m3x5_prod", 32'(ifW4.prod), 32'hF1);

        applyStimulus(4'hD, 4'd5, 1'b0);
        waitDone(n);
        checkOutput("u13x5_prod", 32'(ifW4.prod), 32'h41);

        applyStimulus(4'h8, 4'h8, 1'b1);
        waitDone(n);
        checkOutput("s_m8xm8_prod", 32'(ifW4.prod), 32'h40);

        @(negedge clk);
        ifW8.valid = 1'b1;
        ifW8.A     = 8'hFF;
        ifW8.B     = 8'hFF;
        @(negedge clk);
        ifW8.valid = 1'b0;
        n = 0;
        while (ifW8.DONE !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w8_latency", 32'(n), 32'd8);
        checkOutput("w8_prod",    32'(ifW8.prod), 32'hFE01);

        // A second request mid-RUN must be dropped without disturbing the first.
        applyStimulus(4'd7, 4'd7, 1'b0);
        doneCount = 0;
        doneAt    = -1;
        readyLow  = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                ifW4.valid = 1'b1;
                ifW4.A     = 4'd3;
                ifW4.B     = 4'd3;
            end
            if (i == 2) ifW4.valid = 1'b0;
            if (ifW4.DONE === 1'b1) begin
                doneCount++;
                if (doneAt < 0) doneAt = i;
            end
            if (i < 4 && ifW4.ready !== 1'b0) readyLow = 0;
            @(negedge clk);
        end
        checkOutput("ign_done_count", 32'(doneCount), 32'd1);
        checkOutput("ign_done_at",    32'(doneAt),    32'd4);
        checkOutput("ign_ready_low",  32'(readyLow),  32'd1);
        checkOutput("ign_prod",       32'(ifW4.prod), 32'h31);

        // Valid held high; the next pair is presented in the DONE cycle.
        @(negedge clk);
        ifW4.valid       = 1'b1;
        ifW4.A           = 4'd2;
        ifW4.B           = 4'd3;
        ifW4.signed_mode = 1'b0;
        @(negedge clk);
        waitDone(n);
        checkOutput("b2b_first_latency", 32'(n), 32'd4);
        checkOutput("b2b_first_prod",    32'(ifW4.prod), 32'h06);
        ifW4.A = 4'd5;
        ifW4.B = 4'd5;
        @(negedge clk);
        ifW4.valid = 1'b0;
        checkOutput("b2b_accept_busy", 32'(ifW4.busy), 32'h1);
        waitDone(n);
        checkOutput("b2b_second_gap",  32'(n), 32'd4);
        checkOutput("b2b_second_prod", 32'(ifW4.prod), 32'h19);

        applyStimulus(4'd5, 4'd5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_prod",  32'(ifW4.prod),  32'h0);
        checkOutput("abort_done",  32'(ifW4.DONE),  32'h0);
        checkOutput("abort_ready", 32'(ifW4.ready), 32'h1);
        checkOutput("abort_busy",  32'(ifW4.busy),  32'h0);
        rst = 1'b1;
        doneCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifW4.DONE === 1'b1) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);

        applyStimulus(4'd7, 4'd7, 1'b0);
        waitDone(n);
        checkOutput("post_latency", 32'(n), 32'd4);
        checkOutput("post_prod",    32'(ifW4.prod), 32'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised shift-add sequential multiplier: accepts two WIDTH-bit operands through a valid/ready handshake, iterates one partial product per clock, and returns a 2·WIDTH-bit product with a one-cycle done pulse. It generalises the 4-bit multiplier top to arbitrary width and adds per-operation signed (two's-complement) mode, backpressure via ready, and a held result register. It sits between operand-producing control logic and any consumer sampling prod on done.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (sampled on clk rising edge; 0 = reset)
- valid  input  1  operand strobe; transfer occurs when valid && ready at a rising edge
- signed_mode  input  1  1 = A, B and prod are two's complement; 0 = unsigned; sampled with A/B
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- ready  output  1  high when idle and able to accept operands
- busy  output  1  high while an operation is in progress
- prod  output  2·WIDTH  product of last completed operation; held until next completion
- DONE  output  1  single-cycle pulse, high in the cycle prod first shows a new result

## Operation
- States: IDLE, RUN. Reset state IDLE.
- IDLE: ready=1, busy=0. On valid=1: capture signed_mode; load mcand = |A|, mplier = |B| (magnitudes when signed_mode=1, raw bits otherwise); neg = signed_mode & (A[W-1] ^ B[W-1]); acc=0; cnt=0; go RUN.
- RUN: ready=0, busy=1. Each cycle: if mplier[0], acc += mcand << cnt (acc 2·WIDTH bits, no overflow possible); mplier >>= 1; cnt++.
- On the RUN cycle with cnt == WIDTH-1: prod <= neg ? -(acc_next) : acc_next (2·WIDTH-bit two's complement); DONE <= 1; go IDLE.
- Magnitude of -2^(W-1) is 2^(W-1), representable in WIDTH unsigned bits; (-2^(W-1))² = 2^(2W-2) fits signed 2·WIDTH. No saturation logic.
- valid while RUN: ignored, operands not captured, no queueing.
- A, B, signed_mode may change freely after capture without affecting the running operation.
- prod holds its value through IDLE and the whole next RUN; only changes on completion or reset.
- Zero operands take the full WIDTH cycles (no early termination).

## Timing
- Reset (rst=0 at edge): state IDLE, prod=0, DONE=0, busy=0, ready=1 after the edge; acc/cnt/mcand/mplier cleared. Reset overrides valid and any in-flight operation; aborted operation produces no DONE and prod is zeroed.
- Capture edge E0 (valid && ready). RUN during cycles after E0..E(WIDTH-1). Result and DONE registered at edge E(WIDTH); DONE high exactly one cycle; ready=1 in that same cycle.
- Latency capture-edge to DONE-high: WIDTH cycles. Throughput: one operation per WIDTH cycles with back-to-back valid (new valid accepted in the DONE cycle).
- DONE never high for two consecutive cycles except on back-to-back operations with WIDTH=... not possible; DONE separated by ≥ WIDTH-1 low cycles.
- ready and busy are registered-state decodes: ready = (state==IDLE), busy = ~ready.

## Test plan
- WIDTH=4, unsigned, A=7, B=7, valid one cycle → DONE 4 cycles after capture edge, prod=8'h31; prod still 8'h31 20 cycles later.
- WIDTH=4, signed_mode=1, A=4'b1101 (-3), B=5 → prod=8'hF1 (-15); same operands signed_mode=0 → prod=8'h41 (65).
- WIDTH=4, signed, A=B=4'b1000 (-8) → prod=8'h40; WIDTH=8 unsigned A=B=8'hFF → prod=16'hFE01 after 8 cycles.
- Start 7×7, drive valid with A=3,B=3 at cycle 2 of RUN → ignored; single DONE with prod=8'h31; ready low throughout RUN.
- Back-to-back: valid held high with 2×3 then 5×5 presented on DONE cycle → DONEs 4 cycles apart, prod 8'h06 then 8'h19.
- Assert rst=0 for one cycle mid-RUN → next cycle prod=0, DONE=0, ready=1, busy=0; no DONE ever issued for aborted operation; subsequent 7×7 completes normally.
